// File: rtl/retire_tracker_pkg.sv
// rtl/retire_tracker_pkg.sv - shared MIPS definitions used by the retire tracker
// Purpose: tracker FSM state type and the syscall instruction encoding.
// Ports: none (package).
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } tracker_state_t;

  localparam logic [31:0] SYSCALL_INSTR = 32'h0000_000C;

endpackage

// File: rtl/retire_tracker_if.sv
// rtl/retire_tracker_if.sv - retire stream in, frozen statistics out
// Purpose: bundles the retire-side inputs and the statistics-side outputs.
// Ports (signals):
//   clear, instr_valid, instr                     driven by the master (core side)
//   instruction_count, cycle_count, run_stats,
//   halted, state                                 driven by the slave (tracker)
interface retire_tracker_if #(
  parameter int CNT_W = 32
) ();

  logic             clear;
  logic             instr_valid;
  logic [31:0]      instr;
  logic [CNT_W-1:0] instruction_count;
  logic [CNT_W-1:0] cycle_count;
  logic             run_stats;
  logic             halted;
  logic [1:0]       state;

  modport master (
    output clear, instr_valid, instr,
    input  instruction_count, cycle_count, run_stats, halted, state
  );

  modport slave (
    input  clear, instr_valid, instr,
    output instruction_count, cycle_count, run_stats, halted, state
  );

endinterface

// File: rtl/retire_tracker_sat_counter.sv
// rtl/retire_tracker_sat_counter.sv - saturating up-counter with synchronous clear
// Purpose: counts inc pulses, sticks at all-ones instead of wrapping.
// Ports:
//   clk    in  1  clock
//   rst_n  in  1  asynchronous active-low reset
//   clr    in  1  synchronous clear, wins over inc
//   inc    in  1  count enable
//   q      out W  count value
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/retire_tracker.sv
// rtl/retire_tracker.sv - retired-instruction / cycle tracker with end-of-program detect
// Purpose: counts retires and active cycles, detects the halt word, waits a
//   drain interval, then holds run_stats high with both counts frozen.
// Ports:
//   clk    in  1  clock
//   rst_n  in  1  asynchronous active-low reset
//   bus    slave modport of retire_tracker_if (clear/instr_valid/instr in;
//          instruction_count/cycle_count/run_stats/halted/state out)
module retire_tracker
  import mips_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter logic [31:0] HALT_INSTR   = SYSCALL_INSTR,
  parameter int          DRAIN_CYCLES = 2
) (
  input logic             clk,
  input logic             rst_n,
  retire_tracker_if.slave bus
);

  // The drain counter is loaded with N-1 so that DONE is reached exactly
  // N edges after the halt retires.
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  tracker_state_t   state;
  logic [3:0]       drainCnt;
  logic             runStats;
  logic             haltedQ;
  logic             isHalt;
  logic             instrInc;
  logic             cycleInc;
  logic [CNT_W-1:0] instrCount;
  logic [CNT_W-1:0] cycleCount;

  assign isHalt = (bus.instr == HALT_INSTR);

  // Retires count only while the program is live; the cycle counter starts
  // on the first retire (counter is 0 in IDLE, so that edge yields 1).
  assign instrInc = bus.instr_valid && ((state == IDLE) || (state == RUN));
  assign cycleInc = ((state == IDLE) && bus.instr_valid) ||
                    (state == RUN) || (state == DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      drainCnt <= '0;
      runStats <= 1'b0;
      haltedQ  <= 1'b0;
    end else if (bus.clear) begin
      state    <= IDLE;
      drainCnt <= '0;
      runStats <= 1'b0;
      haltedQ  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.instr_valid) begin
            if (isHalt) begin
              state    <= DRAIN;
              drainCnt <= DRAIN_LOAD;
              haltedQ  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (bus.instr_valid && isHalt) begin
            state    <= DRAIN;
            drainCnt <= DRAIN_LOAD;
            haltedQ  <= 1'b1;
          end
        end
        DRAIN: begin
          if (drainCnt == 4'd0) begin
            state    <= DONE;
            runStats <= 1'b1;
          end else begin
            drainCnt <= drainCnt - 4'd1;
          end
        end
        DONE: begin
          // Held until clear or reset so run_stats never re-pulses.
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) uInstrCount (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (bus.clear),
    .inc  (instrInc),
    .q    (instrCount)
  );

  sat_counter #(.W(CNT_W)) uCycleCount (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (bus.clear),
    .inc  (cycleInc),
    .q    (cycleCount)
  );

  assign bus.instruction_count = instrCount;
  assign bus.cycle_count       = cycleCount;
  assign bus.run_stats         = runStats;
  assign bus.halted            = haltedQ;
  assign bus.state             = state;

endmodule

// File: tb/tb_retire_tracker.sv
// tb/tb_retire_tracker.sv - self-checking bench for retire_tracker
module tb_retire_tracker;

  localparam logic [31:0] NOP  = 32'h2008_0001;
  localparam logic [31:0] HALT = 32'h0000_000C;

  logic clk;
  logic rst_n;

  retire_tracker_if #(.CNT_W(32)) if32 ();
  retire_tracker_if #(.CNT_W(4))  if4 ();

  retire_tracker #(.CNT_W(32), .HALT_INSTR(HALT), .DRAIN_CYCLES(2)) dut32 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if32)
  );

  retire_tracker #(.CNT_W(4), .HALT_INSTR(HALT), .DRAIN_CYCLES(2)) dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        sel;   // 0: 32-bit instance, 1: 4-bit instance
    logic        clr;
    logic        vld;
    logic [31:0] ins;
    logic [31:0] icnt;
    logic [31:0] ccnt;
    logic [1:0]  st;
    logic        rs;
    logic        hl;
  } vec_t;

  vec_t tbl[$];
  vec_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   stepNo = 0;

  function automatic vec_t mk(input logic clr, input logic vld, input logic [31:0] ins,
                              input logic [31:0] icnt, input logic [31:0] ccnt,
                              input logic [1:0] st, input logic rs, input logic hl);
    vec_t v;
    v.sel = 1'b0; v.clr = clr; v.vld = vld; v.ins = ins;
    v.icnt = icnt; v.ccnt = ccnt; v.st = st; v.rs = rs; v.hl = hl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", nm, stepNo, act, exp);
    end
  endtask

  task automatic check_next();
    vec_t e;
    stepNo++;
    if (expq.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
      return;
    end
    e = expq.pop_front();
    if (e.sel) begin
      chk("icnt4", 64'(if4.instruction_count), 64'(e.icnt));
      chk("ccnt4", 64'(if4.cycle_count), 64'(e.ccnt));
      chk("state4", 64'(if4.state), 64'(e.st));
      chk("run_stats4", 64'(if4.run_stats), 64'(e.rs));
      chk("halted4", 64'(if4.halted), 64'(e.hl));
    end else begin
      chk("icnt", 64'(if32.instruction_count), 64'(e.icnt));
      chk("ccnt", 64'(if32.cycle_count), 64'(e.ccnt));
      chk("state", 64'(if32.state), 64'(e.st));
      chk("run_stats", 64'(if32.run_stats), 64'(e.rs));
      chk("halted", 64'(if32.halted), 64'(e.hl));
    end
  endtask

  task automatic apply(input vec_t v);
    if32.clear = 1'b0; if32.instr_valid = 1'b0; if32.instr = '0;
    if4.clear  = 1'b0; if4.instr_valid  = 1'b0; if4.instr  = '0;
    if (v.sel) begin
      if4.clear = v.clr; if4.instr_valid = v.vld; if4.instr = v.ins;
    end else begin
      if32.clear = v.clr; if32.instr_valid = v.vld; if32.instr = v.ins;
    end
    expq.push_back(v);
    @(posedge clk);
    #1;
    check_next();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_icnt"}, 64'(if32.instruction_count), 64'd0);
    chk({tag, "_ccnt"}, 64'(if32.cycle_count), 64'd0);
    chk({tag, "_state"}, 64'(if32.state), 64'd0);
    chk({tag, "_run_stats"}, 64'(if32.run_stats), 64'd0);
    chk({tag, "_halted"}, 64'(if32.halted), 64'd0);
    chk({tag, "_icnt4"}, 64'(if4.instruction_count), 64'd0);
    chk({tag, "_run_stats4"}, 64'(if4.run_stats), 64'd0);
  endtask

  initial begin
    vec_t v;

    // Five ordinary words then halt; DONE ignores further retires.
    tbl.push_back(mk(0, 1, NOP,  1, 1, 2'd1, 0, 0));
    tbl.push_back(mk(0, 1, NOP,  2, 2, 2'd1, 0, 0));
    tbl.push_back(mk(0, 1, NOP,  3, 3, 2'd1, 0, 0));
    tbl.push_back(mk(0, 1, NOP,  4, 4, 2'd1, 0, 0));
    tbl.push_back(mk(0, 1, NOP,  5, 5, 2'd1, 0, 0));
    tbl.push_back(mk(0, 1, HALT, 6, 6, 2'd2, 0, 1));
    tbl.push_back(mk(0, 0, 0,    6, 7, 2'd2, 0, 1));
    tbl.push_back(mk(0, 0, 0,    6, 8, 2'd3, 1, 1));
    tbl.push_back(mk(0, 1, NOP,  6, 8, 2'd3, 1, 1));
    tbl.push_back(mk(0, 1, HALT, 6, 8, 2'd3, 1, 1));
    tbl.push_back(mk(1, 0, 0,    0, 0, 2'd0, 0, 0));
    // Halt as the very first word; retires during DRAIN not counted.
    tbl.push_back(mk(0, 1, HALT, 1, 1, 2'd2, 0, 1));
    tbl.push_back(mk(0, 1, NOP,  1, 2, 2'd2, 0, 1));
    tbl.push_back(mk(0, 1, HALT, 1, 3, 2'd3, 1, 1));
    tbl.push_back(mk(1, 0, 0,    0, 0, 2'd0, 0, 0));
    // Halt pattern without instr_valid is ignored in IDLE and RUN.
    tbl.push_back(mk(0, 0, HALT, 0, 0, 2'd0, 0, 0));
    tbl.push_back(mk(0, 1, NOP,  1, 1, 2'd1, 0, 0));
    tbl.push_back(mk(0, 0, HALT, 1, 2, 2'd1, 0, 0));
    tbl.push_back(mk(0, 0, HALT, 1, 3, 2'd1, 0, 0));
    tbl.push_back(mk(0, 1, HALT, 2, 4, 2'd2, 0, 1));
    tbl.push_back(mk(0, 1, HALT, 2, 5, 2'd2, 0, 1));
    tbl.push_back(mk(0, 1, NOP,  2, 6, 2'd3, 1, 1));
    // Clear on the halt edge wins, then a 3-word program.
    tbl.push_back(mk(1, 0, 0,    0, 0, 2'd0, 0, 0));
    tbl.push_back(mk(0, 1, NOP,  1, 1, 2'd1, 0, 0));
    tbl.push_back(mk(0, 1, NOP,  2, 2, 2'd1, 0, 0));
    tbl.push_back(mk(1, 1, HALT, 0, 0, 2'd0, 0, 0));
    tbl.push_back(mk(0, 0, 0,    0, 0, 2'd0, 0, 0));
    tbl.push_back(mk(0, 1, NOP,  1, 1, 2'd1, 0, 0));
    tbl.push_back(mk(0, 1, NOP,  2, 2, 2'd1, 0, 0));
    tbl.push_back(mk(0, 1, HALT, 3, 3, 2'd2, 0, 1));
    tbl.push_back(mk(0, 0, 0,    3, 4, 2'd2, 0, 1));
    // Clear on the drain-expiry edge wins: run_stats never rises.
    tbl.push_back(mk(1, 0, 0,    0, 0, 2'd0, 0, 0));
    tbl.push_back(mk(0, 0, 0,    0, 0, 2'd0, 0, 0));

    rst_n = 1'b0;
    if32.clear = 1'b0; if32.instr_valid = 1'b0; if32.instr = '0;
    if4.clear  = 1'b0; if4.instr_valid  = 1'b0; if4.instr  = '0;
    #12;
    check_reset("reset");
    rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // 4-bit instance: both counters saturate at 15.
    for (int k = 1; k <= 20; k++) begin
      v = mk(0, 1, NOP, (k > 15) ? 32'd15 : 32'(k), (k > 15) ? 32'd15 : 32'(k), 2'd1, 0, 0);
      v.sel = 1'b1;
      apply(v);
    end
    v = mk(0, 1, HALT, 15, 15, 2'd2, 0, 1); v.sel = 1'b1; apply(v);
    v = mk(0, 0, 0,    15, 15, 2'd2, 0, 1); v.sel = 1'b1; apply(v);
    v = mk(0, 0, 0,    15, 15, 2'd3, 1, 1); v.sel = 1'b1; apply(v);
    v = mk(1, 0, 0,     0,  0, 2'd0, 0, 0); v.sel = 1'b1; apply(v);

    // Asynchronous reset between edges in the middle of DRAIN.
    apply(mk(0, 1, NOP,  1, 1, 2'd1, 0, 0));
    apply(mk(0, 1, HALT, 2, 2, 2'd2, 0, 1));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    @(posedge clk);
    #1;
    check_reset("rst_held");
    rst_n = 1'b1;
    apply(mk(0, 0, 0,    0, 0, 2'd0, 0, 0));
    apply(mk(0, 0, HALT, 0, 0, 2'd0, 0, 0));
    apply(mk(0, 1, NOP,  1, 1, 2'd1, 0, 0));
    apply(mk(0, 1, HALT, 2, 2, 2'd2, 0, 1));
    apply(mk(0, 0, 0,    2, 3, 2'd2, 0, 1));
    apply(mk(0, 0, 0,    2, 4, 2'd3, 1, 1));

    chk("scoreboard_drained", 64'(expq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
